// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
// Purpose: frame-state enum, set-2 prefix codes, game key codes and a parity helper.
// Ports: none (package).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_W     = 8'h1D;

  // Odd parity over data plus parity bit: the XOR of all nine bits is 1.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame receiver
// Purpose: synchronises the PS/2 pins, detects falling clock edges, deframes
//   start/8 data/odd parity/stop, and aborts stalled frames after a timeout.
// Ports:
//   clock      in   system clock
//   resetn     in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock pin
//   ps2_dat    in   raw PS/2 data pin
//   data       out  last accepted byte (valid with byte_strb)
//   byte_strb  out  one-cycle pulse when a byte is accepted
//   frame_err  out  one-cycle pulse on bad start, parity, stop or timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       byte_strb,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  frame_state_t state, state_next;
  logic [7:0]   shreg;
  logic [2:0]   bitcnt;
  logic         parity;
  logic [TW-1:0] tcnt;
  logic         accept;
  logic         err;
  logic         timeout;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // Lines idle high, so the synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  // An edge in the same cycle as the timeout wins: the counter restarts instead.
  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          if (!dat_s) state_next = DATA;
          else        err        = 1'b1;
        end
      end
      DATA: begin
        if (fall && bitcnt == 3'd7) state_next = PARITY;
      end
      PARITY: begin
        if (fall) state_next = STOP;
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (odd_parity_ok(shreg, parity) && dat_s) accept = 1'b1;
          else                                        err    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout) begin
      state_next = IDLE;
      err        = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      parity    <= 1'b0;
      tcnt      <= '0;
      data      <= '0;
      byte_strb <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      byte_strb <= accept;
      frame_err <= err;
      if (accept) data <= shreg;

      if (state == IDLE || fall || timeout) tcnt <= '0;
      else                                  tcnt <= tcnt + TW'(1);

      if (state == IDLE && fall) bitcnt <= '0;
      if (state == DATA && fall) begin
        shreg  <= {dat_s, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (state == PARITY && fall) parity <= dat_s;
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 set-2 scan-code receiver presenting the held key
// Purpose: decodes make/break/extended sequences from ps2_frame_rx into a level
//   key code. Optional saturating frame-error counter under PS2_ERR_CNT_EN.
// Ports:
//   clock      in   system clock
//   resetn     in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock pin
//   ps2_dat    in   raw PS/2 data pin
//   key        out  make code of the held key, 8'h00 when none
//   key_ext    out  1 when key was preceded by E0
//   key_valid  out  one-cycle pulse when key changes to a new non-zero code
//   frame_err  out  one-cycle pulse on any frame error
//   err_count  out  saturating frame-error count (PS2_ERR_CNT_EN only)
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key,
  output logic       key_ext,
  output logic       key_valid,
`ifdef PS2_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  output logic       frame_err
);

  logic [7:0] rx_data;
  logic       rx_strb;
  logic       ext_pend;
  logic       brk_pend;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame_rx (
    .clock    (clock),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .data     (rx_data),
    .byte_strb(rx_strb),
    .frame_err(frame_err)
  );

  // Prefix flags only change on accepted bytes, so they survive frame errors.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key       <= '0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (rx_strb) begin
        if (rx_data == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_data == PS2_BREAK) begin
          brk_pend <= 1'b1;
        end else if (brk_pend) begin
          // Release of a key other than the held one leaves the held key alone.
          if (rx_data == key && ext_pend == key_ext) begin
            key     <= '0;
            key_ext <= 1'b0;
          end
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end else begin
          // Typematic repeats of the held key are absorbed here.
          if (rx_data != key || ext_pend != key_ext) begin
            key       <= rx_data;
            key_ext   <= ext_pend;
            key_valid <= (rx_data != 8'h00);
          end
          ext_pend <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_ERR_CNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                           err_count <= '0;
    else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
